// File: rtl/rvfi_csr_access_ctrl.sv
// rvfi_csr_access_ctrl
// Puts Zicsr instructions (CSRRW/S/C and their immediate forms) from two requesters onto one
// single-ported CSR file. Port 0 is the core pipeline and port 1 is the debug module. Each
// read-modify-write runs as discrete READ / CAPT / WRITE cycles. Every access produces an
// RVFI-style record (rmask/rdata/wmask/wdata) that the csrw checks can consume directly.
//
// Ports
//   clock, reset           : clock; synchronous active-high reset
//   req_valid/req_ready    : per-requester handshake; grant is one-hot and only given in IDLE
//   req_op                 : funct3[1:0] per requester (1=RW, 2=RS, 3=RC, 0=illegal)
//   req_csr/req_src        : CSR index and rs1/uimm operand per requester
//   req_src_x0/req_rd_x0   : operand field is zero / rd is x0 (these suppress the write / read)
//   csr_addr/re/rdata      : CSR file read port; rdata is valid the cycle after re
//   csr_hwmask             : writable-bit mask for csr_addr
//   csr_we/csr_wdata       : CSR file write port
//   rsp_*                  : response handshake plus the access record
module rvfi_csr_access_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [3:0]            req_op,
  input  logic [2*CSR_AW-1:0]   req_csr,
  input  logic [2*XLEN-1:0]     req_src,
  input  logic [1:0]            req_src_x0,
  input  logic [1:0]            req_rd_x0,
  output logic [CSR_AW-1:0]     csr_addr,
  output logic                  csr_re,
  input  logic [XLEN-1:0]       csr_rdata,
  input  logic [XLEN-1:0]       csr_hwmask,
  output logic                  csr_we,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic                  rsp_illegal,
  output logic [XLEN-1:0]       rsp_rmask,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic [XLEN-1:0]       rsp_wmask,
  output logic [XLEN-1:0]       rsp_wdata
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StCapt  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic [1:0]        op_q, op_d;
  logic [CSR_AW-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic              do_read_q, do_read_d;
  logic              do_write_q, do_write_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic [XLEN-1:0]   wmask_q, wmask_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              any_valid, gnt;
  logic [1:0]        sel_op;
  logic [CSR_AW-1:0] sel_csr;
  logic [XLEN-1:0]   sel_src;
  logic              sel_src_x0, sel_rd_x0, sel_do_read, sel_do_write;
  logic [XLEN-1:0]   new_val;
  logic [2:0]        st;

  // Output decode treats the reset cycle as IDLE, so nothing is strobed while reset is high.
  assign st = reset ? StIdle : state_q;

  assign any_valid = |req_valid;
  // The pointer only matters when both requesters are valid.
  assign gnt = (req_valid == 2'b11) ? ptr_q : req_valid[1];

  always_comb begin
    sel_op     = req_op[1:0];
    sel_csr    = req_csr[CSR_AW-1:0];
    sel_src    = req_src[XLEN-1:0];
    sel_src_x0 = req_src_x0[0];
    sel_rd_x0  = req_rd_x0[0];
    if (gnt) begin
      sel_op     = req_op[3:2];
      sel_csr    = req_csr[2*CSR_AW-1:CSR_AW];
      sel_src    = req_src[2*XLEN-1:XLEN];
      sel_src_x0 = req_src_x0[1];
      sel_rd_x0  = req_rd_x0[1];
    end
    sel_do_read  = (sel_op != 2'd0) && ((sel_op != 2'd1) || !sel_rd_x0);
    sel_do_write = (sel_op != 2'd0) && ((sel_op == 2'd1) || !sel_src_x0);
  end

  always_comb begin
    new_val = '0;
    case (op_q)
      2'd1:    new_val = src_q;
      2'd2:    new_val = old_q | src_q;
      2'd3:    new_val = old_q & ~src_q;
      default: new_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    addr_d     = addr_q;
    src_d      = src_q;
    do_read_d  = do_read_q;
    do_write_d = do_write_q;
    illegal_d  = illegal_q;
    old_d      = old_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    case (state_q)
      StIdle: begin
        if (any_valid) begin
          ptr_d      = ~gnt;
          id_d       = gnt;
          op_d       = sel_op;
          addr_d     = sel_csr;
          src_d      = sel_src;
          do_read_d  = sel_do_read;
          do_write_d = sel_do_write;
          illegal_d  = (sel_op == 2'd0);
          if (sel_op == 2'd0) state_d = StResp;
          else if (sel_do_read) state_d = StRead;
          else state_d = StWrite;
        end
      end
      StRead:  state_d = StCapt;
      StCapt: begin
        old_d   = csr_rdata;
        state_d = do_write_q ? StWrite : StResp;
      end
      StWrite: begin
        wmask_d = csr_hwmask;
        wdata_d = new_val & csr_hwmask;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= 1'b0;
      id_q       <= 1'b0;
      op_q       <= 2'd0;
      addr_q     <= '0;
      src_q      <= '0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
      old_q      <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      do_read_q  <= do_read_d;
      do_write_q <= do_write_d;
      illegal_q  <= illegal_d;
      old_q      <= old_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if ((st == StIdle) && any_valid && !reset) req_ready = gnt ? 2'b10 : 2'b01;
    csr_addr    = reset ? '0 : addr_q;
    csr_re      = (st == StRead);
    csr_we      = (st == StWrite);
    csr_wdata   = csr_we ? new_val : '0;
    rsp_valid   = (st == StResp);
    rsp_id      = rsp_valid & id_q;
    rsp_illegal = rsp_valid & illegal_q;
    rsp_rmask   = (rsp_valid && do_read_q)  ? '1      : '0;
    rsp_rdata   = (rsp_valid && do_read_q)  ? old_q   : '0;
    rsp_wmask   = (rsp_valid && do_write_q) ? wmask_q : '0;
    rsp_wdata   = (rsp_valid && do_write_q) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_rvfi_csr_access_ctrl.sv
module tb_rvfi_csr_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [23:0] req_csr;
  logic [63:0] req_src;
  logic [1:0]  req_src_x0;
  logic [1:0]  req_rd_x0;
  logic [11:0] csr_addr;
  logic        csr_re;
  logic [31:0] csr_rdata;
  logic [31:0] csr_hwmask;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_illegal;
  logic [31:0] rsp_rmask, rsp_rdata, rsp_wmask, rsp_wdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  rvfi_csr_access_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
    .req_src(req_src), .req_src_x0(req_src_x0), .req_rd_x0(req_rd_x0),
    .csr_addr(csr_addr), .csr_re(csr_re), .csr_rdata(csr_rdata), .csr_hwmask(csr_hwmask),
    .csr_we(csr_we), .csr_wdata(csr_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_illegal(rsp_illegal),
    .rsp_rmask(rsp_rmask), .rsp_rdata(rsp_rdata), .rsp_wmask(rsp_wmask), .rsp_wdata(rsp_wdata)
  );

  typedef struct {
    int          port;
    logic [1:0]  op;
    logic [11:0] csr;
    logic [31:0] src;
    logic        sx0;
    logic        rx0;
    logic [31:0] rdata;
    logic [31:0] hwmask;
    int          exp_re;
    int          exp_we;
    logic [31:0] exp_cwd;
    logic [31:0] exp_rmask;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wmask;
    logic [31:0] exp_wdata;
    int          exp_lat;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic [1:0] op, input logic [11:0] csr,
                       input logic [31:0] src, input logic sx0, input logic rx0);
    if (p == 0) begin
      req_op[1:0] = op; req_csr[11:0] = csr; req_src[31:0] = src;
      req_src_x0[0] = sx0; req_rd_x0[0] = rx0;
    end else begin
      req_op[3:2] = op; req_csr[23:12] = csr; req_src[63:32] = src;
      req_src_x0[1] = sx0; req_rd_x0[1] = rx0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic all_zero();
    return ~|{req_ready, csr_re, csr_we, csr_addr, csr_wdata, rsp_valid, rsp_id, rsp_illegal,
              rsp_rmask, rsp_rdata, rsp_wmask, rsp_wdata};
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    int lat, nre, nwe;
    logic [31:0] wd;
    logic addr_bad;
    v = vecs[i];
    lat = 0; nre = 0; nwe = 0; wd = '0; addr_bad = 1'b0;
    @(negedge clock);
    csr_rdata = v.rdata;
    csr_hwmask = v.hwmask;
    drive(v.port, v.op, v.csr, v.src, v.sx0, v.rx0);
    req_valid = (v.port == 0) ? 2'b01 : 2'b10;
    #1;
    check($sformatf("v%0d req_ready", i), {62'd0, req_ready}, {62'd0, req_valid});
    @(posedge clock);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      req_valid = 2'b00;
      if (csr_re) begin nre++; if (csr_addr != v.csr) addr_bad = 1'b1; end
      if (csr_we) begin nwe++; wd = csr_wdata; if (csr_addr != v.csr) addr_bad = 1'b1; end
      if (rsp_valid) begin lat = c; break; end
    end
    check($sformatf("v%0d latency", i), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d csr_re count", i), 64'(nre), 64'(v.exp_re));
    check($sformatf("v%0d csr_we count", i), 64'(nwe), 64'(v.exp_we));
    check($sformatf("v%0d csr_wdata", i), {32'd0, wd}, {32'd0, v.exp_cwd});
    check($sformatf("v%0d csr_addr", i), {63'd0, addr_bad}, 64'd0);
    check($sformatf("v%0d rsp_id", i), {63'd0, rsp_id}, 64'(v.port));
    check($sformatf("v%0d rsp_illegal", i), {63'd0, rsp_illegal}, {63'd0, v.exp_ill});
    check($sformatf("v%0d rsp_rmask", i), {32'd0, rsp_rmask}, {32'd0, v.exp_rmask});
    check($sformatf("v%0d rsp_rdata", i), {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
    check($sformatf("v%0d rsp_wmask", i), {32'd0, rsp_wmask}, {32'd0, v.exp_wmask});
    check($sformatf("v%0d rsp_wdata", i), {32'd0, rsp_wdata}, {32'd0, v.exp_wdata});
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    check($sformatf("v%0d rsp dropped", i), {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    int grants[4];
    int ng, cyc;
    logic stable, seen_we;
    logic [127:0] snap;

    //          port op  csr     src           sx0   rx0   rdata         hwmask
    //          re we cwd           rmask         rdata         wmask         wdata        lat ill
    vecs[0] = '{0, 2'd2, 12'h300, 32'h8,        1'b0, 1'b0, 32'h1800,     32'hFFFFFFFF,
                1, 1, 32'h1808,     32'hFFFFFFFF, 32'h1800,     32'hFFFFFFFF, 32'h1808,    4, 1'b0};
    vecs[1] = '{1, 2'd1, 12'h340, 32'hDEADBEEF, 1'b0, 1'b1, 32'h12345678, 32'h0000FFFF,
                0, 1, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0000FFFF, 32'h0000BEEF, 2, 1'b0};
    vecs[2] = '{0, 2'd3, 12'h305, 32'h0,        1'b1, 1'b0, 32'h55,       32'hFFFFFFFF,
                1, 0, 32'h0,        32'hFFFFFFFF, 32'h55,       32'h0,        32'h0,       3, 1'b0};
    vecs[3] = '{1, 2'd3, 12'h344, 32'h0F,       1'b0, 1'b0, 32'hFF,       32'h000000F0,
                1, 1, 32'hF0,       32'hFFFFFFFF, 32'hFF,       32'h000000F0, 32'hF0,      4, 1'b0};
    vecs[4] = '{0, 2'd1, 12'h341, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h11111111, 32'hFFFF0000,
                1, 1, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h11111111, 32'hFFFF0000, 32'hA5A50000, 4, 1'b0};
    vecs[5] = '{1, 2'd0, 12'h7C0, 32'h77,       1'b0, 1'b0, 32'h99,       32'hFFFFFFFF,
                0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,       1, 1'b1};
    vecs[6] = '{0, 2'd2, 12'h304, 32'h3,        1'b0, 1'b1, 32'h4,        32'hFFFFFFFF,
                1, 1, 32'h7,        32'hFFFFFFFF, 32'h4,        32'hFFFFFFFF, 32'h7,       4, 1'b0};

    reset = 1'b1; req_valid = 2'b00; req_op = '0; req_csr = '0; req_src = '0;
    req_src_x0 = '0; req_rd_x0 = '0; csr_rdata = '0; csr_hwmask = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("reset outputs zero", {63'd0, all_zero()}, 64'd1);
    reset = 1'b0;
    @(negedge clock);
    check("idle outputs zero", {63'd0, all_zero()}, 64'd1);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Both requesters continuously valid: grants must alternate starting at port 0.
    do_reset();
    csr_hwmask = 32'hFFFFFFFF;
    drive(0, 2'd1, 12'h340, 32'h1111, 1'b0, 1'b1);
    drive(1, 2'd1, 12'h341, 32'h2222, 1'b0, 1'b1);
    req_valid = 2'b11; rsp_ready = 1'b1; ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req_ready == 2'b11) check("grant onehot", {62'd0, req_ready}, 64'd1);
      else if (req_ready != 2'b00) begin grants[ng] = req_ready[1] ? 1 : 0; ng++; end
      if (rsp_valid) check("rr rsp_wdata", {32'd0, rsp_wdata}, rsp_id ? 64'h2222 : 64'h1111);
      @(negedge clock);
    end
    check("rr grant count", 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++) check($sformatf("rr grant %0d", k), 64'(grants[k]), 64'(k % 2));
    req_valid = 2'b00;
    repeat (4) @(negedge clock);
    rsp_ready = 1'b0;

    // Response back-pressure: fields stable, no grant while stalled or on the acceptance cycle.
    csr_rdata = 32'h1800;
    drive(0, 2'd2, 12'h300, 32'h8, 1'b0, 1'b0);
    drive(1, 2'd1, 12'h341, 32'h5, 1'b0, 1'b1);
    req_valid = 2'b01;
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b10;
    cyc = 0;
    while (!rsp_valid && cyc < 10) begin @(negedge clock); cyc++; end
    check("stall rsp reached", {63'd0, rsp_valid}, 64'd1);
    snap = {rsp_rmask, rsp_rdata, rsp_wmask, rsp_wdata};
    for (int c = 0; c < 5; c++) begin
      stable = rsp_valid && (snap == {rsp_rmask, rsp_rdata, rsp_wmask, rsp_wdata});
      check($sformatf("stall stable %0d", c), {63'd0, stable}, 64'd1);
      check($sformatf("stall req_ready %0d", c), {62'd0, req_ready}, 64'd0);
      @(negedge clock);
    end
    check("stall rsp_wdata", {32'd0, rsp_wdata}, 64'h1808);
    rsp_ready = 1'b1;
    #1;
    check("accept cycle req_ready", {62'd0, req_ready}, 64'd0);
    @(negedge clock);
    rsp_ready = 1'b0;
    check("post accept grant", {62'd0, req_ready}, 64'd2);
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    cyc = 0;
    while (!rsp_valid && cyc < 10) begin @(negedge clock); cyc++; end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;

    // Reset in CAPT of an RS access aborts it; the pointer returns to port 0.
    do_reset();
    csr_rdata = 32'h1;
    drive(0, 2'd2, 12'h300, 32'h2, 1'b0, 1'b0);
    req_valid = 2'b01;
    @(posedge clock);
    seen_we = 1'b0;
    repeat (2) begin @(negedge clock); req_valid = 2'b00; seen_we |= csr_we; end
    reset = 1'b1;
    #1;
    seen_we |= csr_we;
    @(negedge clock);
    check("reset-abort outputs zero", {63'd0, all_zero()}, 64'd1);
    reset = 1'b0;
    drive(0, 2'd0, 12'h300, 32'h1, 1'b0, 1'b0);
    drive(1, 2'd0, 12'h301, 32'h1, 1'b0, 1'b0);
    req_valid = 2'b11;
    #1;
    seen_we |= csr_we;
    check("reset-abort no we", {63'd0, seen_we}, 64'd0);
    check("reset ptr grant", {62'd0, req_ready}, 64'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 2'b00;
    check("illegal rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("illegal flag", {63'd0, rsp_illegal}, 64'd1);
    check("illegal no access", {62'd0, csr_re, csr_we}, 64'd0);
    check("illegal record", {rsp_rmask, rsp_wmask}, 64'd0);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
